// File: rtl/tt_codelock_pkg.sv
// Shared types and constants for the digit-entry combination lock.
// The helper below sizes the shared OPEN/LOCKOUT countdown timer.
package tt_codelock_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ENTRY   = 2'd1,
    ST_OPEN    = 2'd2,
    ST_LOCKOUT = 2'd3
  } state_t;

  localparam logic [3:0] CANCEL_DIGIT = 4'hF;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/tt_strobe_sync.sv
// Two-flop synchroniser for an asynchronous strobe, plus a history flop
// so that each rising edge yields exactly one single-cycle pulse.
module tt_strobe_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic pulse
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= async_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign pulse = r_s2 & ~r_s3;

endmodule

// File: rtl/tt_codelock.sv
// Combination lock: counts synchronised digit strobes, compares them with
// CODE and drives timed unlock / lockout windows and a one-cycle fail pulse.
module tt_codelock
  import tt_codelock_pkg::*;
#(
  parameter int                    CODE_LEN       = 4,
  parameter logic [4*CODE_LEN-1:0] CODE           = 16'h1234,
  parameter int                    MAX_FAILS      = 3,
  parameter int                    UNLOCK_CYCLES  = 500,
  parameter int                    LOCKOUT_CYCLES = 1000
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             sample,
  input  logic [3:0]                       samplednum,
  output logic                             unlocked,
  output logic                             locked_out,
  output logic                             fail,
  output logic [$clog2(CODE_LEN+1)-1:0]    digit_count,
  output logic [$clog2(MAX_FAILS+1)-1:0]   fail_count
);

  localparam int DC_W  = $clog2(CODE_LEN + 1);
  localparam int FC_W  = $clog2(MAX_FAILS + 1);
  localparam int TW    = $clog2(max_int(UNLOCK_CYCLES, LOCKOUT_CYCLES) + 1);
  localparam int NIB_N = 2 ** DC_W;

  logic            w_strobe;
  logic [3:0]      w_code_nib [NIB_N];
  logic            w_digit_bad;
  logic [DC_W-1:0] w_dc_inc;
  logic [FC_W-1:0] w_fc_inc;

  state_t          r_state;
  logic [DC_W-1:0] r_digit_count;
  logic            r_mismatch;
  logic [FC_W-1:0] r_fail_count;
  logic [TW-1:0]   r_timer;
  logic            r_fail;

  state_t          w_state_next;
  logic [DC_W-1:0] w_dc_next;
  logic            w_mm_next;
  logic [FC_W-1:0] w_fc_next;
  logic [TW-1:0]   w_timer_next;
  logic            w_fail_next;

  tt_strobe_sync u_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (sample),
    .pulse    (w_strobe)
  );

  // Expected digit table indexed by digit_count; first digit is the top nibble.
  // Padding entries are never addressed because digit_count < CODE_LEN in ENTRY.
  genvar gi;
  generate
    for (gi = 0; gi < NIB_N; gi++) begin : g_nib
      if (gi < CODE_LEN) begin : g_code
        assign w_code_nib[gi] = CODE[4*(CODE_LEN-1-gi) +: 4];
      end else begin : g_pad
        assign w_code_nib[gi] = 4'h0;
      end
    end
  endgenerate

  assign w_digit_bad = (samplednum != w_code_nib[r_digit_count]);
  assign w_dc_inc    = r_digit_count + DC_W'(1);
  assign w_fc_inc    = r_fail_count + FC_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_digit_count <= '0;
      r_mismatch    <= 1'b0;
      r_fail_count  <= '0;
      r_timer       <= '0;
      r_fail        <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_digit_count <= w_dc_next;
      r_mismatch    <= w_mm_next;
      r_fail_count  <= w_fc_next;
      r_timer       <= w_timer_next;
      r_fail        <= w_fail_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_dc_next    = r_digit_count;
    w_mm_next    = r_mismatch;
    w_fc_next    = r_fail_count;
    w_timer_next = r_timer;
    w_fail_next  = 1'b0;

    case (r_state)
      // IDLE and ENTRY share digit handling: IDLE always has digit_count 0.
      ST_IDLE, ST_ENTRY: begin
        if (w_strobe) begin
          if (samplednum == CANCEL_DIGIT) begin
            w_state_next = ST_IDLE;
            w_dc_next    = '0;
            w_mm_next    = 1'b0;
          end else if (w_dc_inc == DC_W'(CODE_LEN)) begin
            w_dc_next = '0;
            w_mm_next = 1'b0;
            if (!(r_mismatch | w_digit_bad)) begin
              w_state_next = ST_OPEN;
              w_timer_next = TW'(UNLOCK_CYCLES);
              w_fc_next    = '0;
            end else begin
              w_fail_next = 1'b1;
              w_fc_next   = w_fc_inc;
              if (w_fc_inc == FC_W'(MAX_FAILS)) begin
                w_state_next = ST_LOCKOUT;
                w_timer_next = TW'(LOCKOUT_CYCLES);
              end else begin
                w_state_next = ST_IDLE;
              end
            end
          end else begin
            w_state_next = ST_ENTRY;
            w_dc_next    = w_dc_inc;
            w_mm_next    = r_mismatch | w_digit_bad;
          end
        end
      end

      ST_OPEN, ST_LOCKOUT: begin
        w_timer_next = r_timer - TW'(1);
        if (r_timer == TW'(1)) begin
          w_state_next = ST_IDLE;
          if (r_state == ST_LOCKOUT) begin
            w_fc_next = '0;
          end
        end
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  assign unlocked    = (r_state == ST_OPEN);
  assign locked_out  = (r_state == ST_LOCKOUT);
  assign fail        = r_fail;
  assign digit_count = r_digit_count;
  assign fail_count  = r_fail_count;

endmodule

// File: tb/tb_tt_codelock.sv
// Scenario bench for tt_codelock: expected per-digit state is queued when a
// digit is driven and compared once the synchronised strobe has taken effect.
module tb_tt_codelock;

  logic       clk = 1'b0;
  logic       rst;
  logic       sample;
  logic [3:0] samplednum;
  logic       unlocked;
  logic       locked_out;
  logic       fail;
  logic [2:0] digit_count;
  logic [1:0] fail_count;

  typedef struct {
    logic [2:0] dc;
    logic [1:0] fc;
    logic       unl;
    logic       lo;
  } exp_t;

  exp_t exp_q[$];

  int n_checks    = 0;
  int n_fails     = 0;
  int fail_pulses = 0;
  int fail_wide   = 0;
  logic fail_prev = 1'b0;
  int unl_run = 0, unl_last = 0, lo_run = 0, lo_last = 0;

  always #5 clk = ~clk;

  tt_codelock #(
    .CODE_LEN       (4),
    .CODE           (16'h1234),
    .MAX_FAILS      (3),
    .UNLOCK_CYCLES  (500),
    .LOCKOUT_CYCLES (1000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sample      (sample),
    .samplednum  (samplednum),
    .unlocked    (unlocked),
    .locked_out  (locked_out),
    .fail        (fail),
    .digit_count (digit_count),
    .fail_count  (fail_count)
  );

  // Pulse counters and completed high-run widths of the timed outputs.
  always @(negedge clk) begin
    fail_prev <= fail;
    if (fail) fail_pulses <= fail_pulses + 1;
    if (fail && fail_prev) fail_wide <= fail_wide + 1;
    if (unlocked) unl_run <= unl_run + 1;
    else if (unl_run != 0) begin unl_last <= unl_run; unl_run <= 0; end
    if (locked_out) lo_run <= lo_run + 1;
    else if (lo_run != 0) begin lo_last <= lo_run; lo_run <= 0; end
  end

  task automatic drive_digit(input logic [3:0] d);
    @(negedge clk);
    samplednum = d;
    sample     = 1'b1;
    repeat (4) @(negedge clk);
    sample = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_idle(input string name);
    int g = 0;
    while ((unlocked === 1'b1 || locked_out === 1'b1) && g < 3000) begin
      @(negedge clk);
      g++;
    end
    if (g >= 3000) begin
      n_checks++;
      n_fails++;
      $display("FAIL %s timeout: still unlocked=%b locked_out=%b, required both 0", name, unlocked, locked_out);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; sample = 1'b0; samplednum = 4'h0;
    repeat (3) @(negedge clk);
    n_checks++; if (unlocked !== 1'b0)   begin n_fails++; $display("FAIL reset_unlocked got %b want 0", unlocked); end
    n_checks++; if (locked_out !== 1'b0) begin n_fails++; $display("FAIL reset_locked_out got %b want 0", locked_out); end
    n_checks++; if (fail !== 1'b0)       begin n_fails++; $display("FAIL reset_fail got %b want 0", fail); end
    n_checks++; if (digit_count !== 3'd0) begin n_fails++; $display("FAIL reset_digit_count got %0d want 0", digit_count); end
    n_checks++; if (fail_count !== 2'd0) begin n_fails++; $display("FAIL reset_fail_count got %0d want 0", fail_count); end
    rst = 1'b0;
    @(negedge clk);
    $display("reset: outputs dc=%0d fc=%0d unl=%b lo=%b", digit_count, fail_count, unlocked, locked_out);
  endtask

  task automatic test_correct_code();
    logic [3:0] d [3] = '{4'h1, 4'h2, 4'h3};
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back('{dc: 3'(i + 1), fc: 2'd0, unl: 1'b0, lo: 1'b0});
      drive_digit(d[i]);
      e = exp_q.pop_front();
      n_checks++;
      if ({digit_count, fail_count, unlocked, locked_out} !== {e.dc, e.fc, e.unl, e.lo}) begin
        n_fails++;
        $display("FAIL correct_code digit %0d: got dc=%0d fc=%0d unl=%b lo=%b, want dc=%0d fc=%0d unl=%b lo=%b",
                 i, digit_count, fail_count, unlocked, locked_out, e.dc, e.fc, e.unl, e.lo);
      end
      $display("correct_code: digit %h dc=%0d fc=%0d", d[i], digit_count, fail_count);
    end
    // Final digit driven by hand to pin down the two-edge latency.
    @(negedge clk); samplednum = 4'h4; sample = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_checks++; if (unlocked !== 1'b0) begin n_fails++; $display("FAIL unlock_latency_early got %b want 0", unlocked); end
    @(negedge clk);
    n_checks++; if (unlocked !== 1'b1) begin n_fails++; $display("FAIL unlock_latency got %b want 1", unlocked); end
    repeat (3) @(negedge clk);
    sample = 1'b0;
    wait_idle("correct_code");
    n_checks++; if (unl_last !== 500) begin n_fails++; $display("FAIL unlock_width got %0d want 500", unl_last); end
    n_checks++; if (fail_count !== 2'd0) begin n_fails++; $display("FAIL correct_fail_count got %0d want 0", fail_count); end
    $display("correct_code: unlocked for %0d cycles", unl_last);
  endtask

  task automatic test_wrong_code();
    logic [3:0] d [4] = '{4'h1, 4'h7, 4'h3, 4'h4};
    int edc [4] = '{1, 2, 3, 0};
    int efc [4] = '{0, 0, 0, 1};
    int f0 = fail_pulses;
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back('{dc: 3'(edc[i]), fc: 2'(efc[i]), unl: 1'b0, lo: 1'b0});
      drive_digit(d[i]);
      e = exp_q.pop_front();
      n_checks++;
      if ({digit_count, fail_count, unlocked, locked_out} !== {e.dc, e.fc, e.unl, e.lo}) begin
        n_fails++;
        $display("FAIL wrong_code digit %0d: got dc=%0d fc=%0d unl=%b lo=%b, want dc=%0d fc=%0d unl=%b lo=%b",
                 i, digit_count, fail_count, unlocked, locked_out, e.dc, e.fc, e.unl, e.lo);
      end
      $display("wrong_code: digit %h dc=%0d fc=%0d", d[i], digit_count, fail_count);
    end
    n_checks++; if (fail_pulses - f0 !== 1) begin n_fails++; $display("FAIL wrong_fail_pulses got %0d want 1", fail_pulses - f0); end
    n_checks++; if (fail_wide !== 0) begin n_fails++; $display("FAIL fail_width got %0d extra cycles want 0", fail_wide); end
  endtask

  task automatic test_lockout();
    logic [3:0] d [8] = '{4'h9, 4'h9, 4'h9, 4'h9, 4'h9, 4'h9, 4'h9, 4'h9};
    int edc [8] = '{1, 2, 3, 0, 1, 2, 3, 0};
    int efc [8] = '{1, 1, 1, 2, 2, 2, 2, 3};
    logic [3:0] c [4] = '{4'h1, 4'h2, 4'h3, 4'h4};
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back('{dc: 3'(edc[i]), fc: 2'(efc[i]), unl: 1'b0, lo: (i == 7)});
      drive_digit(d[i]);
      e = exp_q.pop_front();
      n_checks++;
      if ({digit_count, fail_count, unlocked, locked_out} !== {e.dc, e.fc, e.unl, e.lo}) begin
        n_fails++;
        $display("FAIL lockout_entry digit %0d: got dc=%0d fc=%0d unl=%b lo=%b, want dc=%0d fc=%0d unl=%b lo=%b",
                 i, digit_count, fail_count, unlocked, locked_out, e.dc, e.fc, e.unl, e.lo);
      end
      $display("lockout: digit %h dc=%0d fc=%0d lo=%b", d[i], digit_count, fail_count, locked_out);
    end
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back('{dc: 3'd0, fc: 2'd3, unl: 1'b0, lo: 1'b1});
      drive_digit(c[i]);
      e = exp_q.pop_front();
      n_checks++;
      if ({digit_count, fail_count, unlocked, locked_out} !== {e.dc, e.fc, e.unl, e.lo}) begin
        n_fails++;
        $display("FAIL lockout_ignore digit %0d: got dc=%0d fc=%0d unl=%b lo=%b, want dc=%0d fc=%0d unl=%b lo=%b",
                 i, digit_count, fail_count, unlocked, locked_out, e.dc, e.fc, e.unl, e.lo);
      end
      $display("lockout: ignored digit %h dc=%0d", c[i], digit_count);
    end
    wait_idle("lockout");
    n_checks++; if (lo_last !== 1000) begin n_fails++; $display("FAIL lockout_width got %0d want 1000", lo_last); end
    n_checks++; if (fail_count !== 2'd0) begin n_fails++; $display("FAIL lockout_exit_fc got %0d want 0", fail_count); end
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back('{dc: 3'((i + 1) % 4), fc: 2'd0, unl: (i == 3), lo: 1'b0});
      drive_digit(c[i]);
      e = exp_q.pop_front();
      n_checks++;
      if ({digit_count, fail_count, unlocked, locked_out} !== {e.dc, e.fc, e.unl, e.lo}) begin
        n_fails++;
        $display("FAIL lockout_recover digit %0d: got dc=%0d fc=%0d unl=%b lo=%b, want dc=%0d fc=%0d unl=%b lo=%b",
                 i, digit_count, fail_count, unlocked, locked_out, e.dc, e.fc, e.unl, e.lo);
      end
      $display("lockout: recovery digit %h dc=%0d unl=%b", c[i], digit_count, unlocked);
    end
    wait_idle("lockout_recover");
  endtask

  task automatic test_cancel();
    logic [3:0] d [7] = '{4'h1, 4'h2, 4'hF, 4'h1, 4'h2, 4'h3, 4'h4};
    int edc [7] = '{1, 2, 0, 1, 2, 3, 0};
    int f0 = fail_pulses;
    exp_t e;
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back('{dc: 3'(edc[i]), fc: 2'd0, unl: (i == 6), lo: 1'b0});
      drive_digit(d[i]);
      e = exp_q.pop_front();
      n_checks++;
      if ({digit_count, fail_count, unlocked, locked_out} !== {e.dc, e.fc, e.unl, e.lo}) begin
        n_fails++;
        $display("FAIL cancel digit %0d: got dc=%0d fc=%0d unl=%b lo=%b, want dc=%0d fc=%0d unl=%b lo=%b",
                 i, digit_count, fail_count, unlocked, locked_out, e.dc, e.fc, e.unl, e.lo);
      end
      $display("cancel: digit %h dc=%0d unl=%b", d[i], digit_count, unlocked);
    end
    n_checks++; if (fail_pulses - f0 !== 0) begin n_fails++; $display("FAIL cancel_fail_pulses got %0d want 0", fail_pulses - f0); end
    wait_idle("cancel");
  endtask

  task automatic test_long_sample();
    @(negedge clk); samplednum = 4'h1; sample = 1'b1;
    repeat (50) @(negedge clk);
    sample = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++; if (digit_count !== 3'd1) begin n_fails++; $display("FAIL long_sample_dc got %0d want 1", digit_count); end
    $display("long_sample: held 50 cycles dc=%0d", digit_count);
    drive_digit(4'hF);
    n_checks++; if (digit_count !== 3'd0) begin n_fails++; $display("FAIL long_sample_cancel got %0d want 0", digit_count); end
  endtask

  task automatic test_reset_mid();
    logic [3:0] c [4] = '{4'h1, 4'h2, 4'h3, 4'h4};
    for (int i = 0; i < 4; i++) drive_digit(c[i]);
    n_checks++; if (unlocked !== 1'b1) begin n_fails++; $display("FAIL mid_open_setup got %b want 1", unlocked); end
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if ({unlocked, digit_count, fail_count} !== 6'd0) begin
      n_fails++; $display("FAIL reset_mid_open got unl=%b dc=%0d fc=%0d want 0 0 0", unlocked, digit_count, fail_count);
    end
    rst = 1'b0;
    $display("reset_mid: OPEN cleared unl=%b", unlocked);
    for (int i = 0; i < 4; i++) drive_digit(4'h5);
    drive_digit(4'h1);
    drive_digit(4'h2);
    n_checks++; if ({digit_count, fail_count} !== {3'd2, 2'd1}) begin
      n_fails++; $display("FAIL mid_entry_setup got dc=%0d fc=%0d want 2 1", digit_count, fail_count);
    end
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if ({unlocked, digit_count, fail_count} !== 6'd0) begin
      n_fails++; $display("FAIL reset_mid_entry got unl=%b dc=%0d fc=%0d want 0 0 0", unlocked, digit_count, fail_count);
    end
    rst = 1'b0;
    $display("reset_mid: ENTRY cleared dc=%0d fc=%0d", digit_count, fail_count);
    // A sample held high through reset must give one fresh strobe afterwards.
    @(negedge clk); samplednum = 4'h3; sample = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++; if (digit_count !== 3'd0) begin n_fails++; $display("FAIL reset_held_clear got %0d want 0", digit_count); end
    repeat (4) @(negedge clk);
    n_checks++; if (digit_count !== 3'd1) begin n_fails++; $display("FAIL reset_held_strobe got %0d want 1", digit_count); end
    sample = 1'b0;
    repeat (4) @(negedge clk);
    $display("reset_mid: held sample after reset dc=%0d", digit_count);
  endtask

  initial begin
    test_reset();
    test_correct_code();
    test_wrong_code();
    test_lockout();
    test_cancel();
    test_long_sample();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/tt_codelock.md
# tt_codelock

Downstream consumer of the serial key sampler: takes its latched 4-bit `samplednum` word and the raw `sample` strobe and runs a digit-entry combination-lock state machine. It synchronises `sample` into the `clk` domain and treats each rising edge as one entered digit. It compares the digit sequence against a parameterised code, then drives unlock, fail and lockout indications to the top-level outputs.

## Interface
- `CODE_LEN`, 4: digits per code, range 1..8.
- `CODE`, 16'h1234: expected digits, first digit in the most significant nibble; width 4*CODE_LEN; no nibble may equal 4'hF.
- `MAX_FAILS`, 3: consecutive failed codes that trigger lockout, ≥1.
- `UNLOCK_CYCLES`, 500: cycles `unlocked` stays high, ≥1.
- `LOCKOUT_CYCLES`, 1000: cycles `locked_out` stays high, ≥1.

Ports:
- `clk` in 1: single clock. Every register is clocked on its rising edge.
- `rst` in 1: synchronous reset, active-high.
- `sample` in 1: asynchronous digit strobe, same signal that clocks the sampler.
- `samplednum` in 4: sampler output, stable between `sample` rising edges.
- `unlocked` out 1: high while in OPEN.
- `locked_out` out 1: high while in LOCKOUT.
- `fail` out 1: one-cycle pulse on a completed wrong code.
- `digit_count` out $clog2(CODE_LEN+1): digits accepted in the current attempt.
- `fail_count` out $clog2(MAX_FAILS+1): consecutive failures.

## Operation
- Strobe path: `sample` passes through 2 sync flops, then a third flop for history. `strobe = s2 & ~s3`. The digit is `samplednum` sampled on the strobe cycle.
- States and behaviour:
  - IDLE (`digit_count` = 0): a strobe moves to ENTRY.
  - ENTRY: each strobe compares the digit with nibble `CODE[4*(CODE_LEN-1-digit_count) +: 4]`. A sticky `mismatch` flag ORs in inequality. `digit_count` increments.
  - Completion: the strobe that makes `digit_count` equal `CODE_LEN` is the completing strobe.
    - If `mismatch` is clear including that digit: go to OPEN, load the timer with UNLOCK_CYCLES, clear `fail_count`.
    - Otherwise pulse `fail` and increment `fail_count`. If the new `fail_count` equals MAX_FAILS, go to LOCKOUT and load LOCKOUT_CYCLES. Otherwise go to IDLE.
    - `digit_count` and `mismatch` clear on every exit from ENTRY.
  - CANCEL_DIGIT: digit 4'hF in IDLE or ENTRY clears `digit_count` and `mismatch` and returns to IDLE. It does not count as a failure and does not pulse `fail`.
  - OPEN and LOCKOUT:
    - Strobes are ignored and no digit is counted.
    - The timer decrements each cycle. When the timer is 1, the next state is IDLE.
    - Leaving LOCKOUT clears `fail_count`.
- With CODE_LEN=1, the first strobe both enters and completes, going directly IDLE→OPEN/IDLE/LOCKOUT.

## Timing
- Reset values: all outputs 0, state IDLE, sync flops 0, timer 0.
- Latency:
  - `sample` rises before clk edge k, so s1=1 at k, s2=1 at k+1, and the strobe is evaluated in cycle k+1.
  - State, counters and `fail` update at edge k+2.
- Upstream requirement: `sample` high and low times must each be ≥3 `clk` periods. Each rising edge yields exactly one strobe, however long `sample` is held high.
- `samplednum` changes only on a `sample` rising edge, so it is stable at least 2 cycles before the strobe is evaluated. No extra capture register is needed.
- Pulse widths:
  - `unlocked` is high for exactly UNLOCK_CYCLES cycles.
  - `locked_out` is high for exactly LOCKOUT_CYCLES cycles.
  - `fail` is high for exactly 1 cycle.
- Reset mid-operation (any state) returns to the reset values on the next edge. A sync-flop history of 1 clears, so a `sample` still high after reset produces one fresh strobe.
- A strobe on the cycle the timer expires is ignored. State is still OPEN or LOCKOUT in that cycle.

## Structure
- Package `tt_codelock_pkg`: state enum {IDLE, ENTRY, OPEN, LOCKOUT}, `CANCEL_DIGIT = 4'hF`.
- Sub-module `tt_strobe_sync`: 2-flop synchroniser plus rising-edge detector, ports `clk`, `rst`, `async_in`, `pulse`.
- Timer width: $clog2(max(UNLOCK_CYCLES, LOCKOUT_CYCLES)+1).

## Test plan
- Correct code: digits 1,2,3,4 → `unlocked` rises 2 cycles after the 4th `sample` edge and stays high 500 cycles; `fail_count` stays 0.
- Wrong second digit: 1,7,3,4 → `fail` pulses once, `fail_count`=1, return to IDLE, `unlocked` stays 0.
- Lockout: three wrong codes → `locked_out` high 1000 cycles. Digits sent during lockout leave `digit_count`=0. On exit, `fail_count`=0 and a correct code then unlocks.
- Cancel: 1,2,F then 1,2,3,4 → `digit_count` goes 1,2,0; the later sequence unlocks; no `fail` pulse.
- Long `sample` high (50 cycles) with digit 1 → exactly one digit counted (`digit_count`=1).
- `rst` asserted mid-OPEN and mid-ENTRY → next edge `unlocked`=0, `digit_count`=0, `fail_count`=0.
